move_tick_gen: RTL and testbench

Parametrised successor to the elevator move-clock generator. It produces the floor-to-floor movement timebase: a one-cycle `move_tick` pulse and a 50%-style `move_clk` toggle every programmed period. It generalises the single fixed period and three call buttons to N synchronised call buttons, two selectable periods (normal/fast) and a hold state with resume. It sits between the call-button inputs and the floor/position controller.

---
 rtl/elevator_pkg.sv | 23 ++
 rtl/btn_sync_edge.sv | 44 ++++
 rtl/move_tick_gen.sv | 129 ++++++++++++
 tb/tb_move_tick_gen.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
`default_nettype none
// ============================================================================
// Module : elevator_pkg
// Brief  : Shared types and constants for the elevator movement timebase.
// Rev    : 1.0  initial release
// ============================================================================
package elevator_pkg;

  // Timebase controller states
  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  // Default floor-to-floor periods in clk cycles
  localparam int MOVE_TIME_DEF = 10;
  localparam int FAST_TIME_DEF = 5;

  // Call buttons pull low when pressed
  localparam logic BTN_ACTIVE = 1'b0;

endpackage
`default_nettype wire

// File: rtl/btn_sync_edge.sv
`default_nettype none
// ============================================================================
// Module : btn_sync_edge
// Brief  : Per-bit 2-FF synchroniser and press-edge detector for raw,
//          asynchronous call buttons. One-cycle pulse per press; a held
//          button does not re-trigger.
// Rev    : 1.0  initial release
// ============================================================================
module btn_sync_edge
  import elevator_pkg::*;
#(
  parameter int NUM_BTN = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] fall
);

  localparam logic c_idle = ~BTN_ACTIVE;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_bit
    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    // Two-stage synchroniser followed by a history flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sync1 <= c_idle;
        r_sync2 <= c_idle;
        r_prev  <= c_idle;
      end else begin
        r_sync1 <= btn_raw[i];
        r_sync2 <= r_sync1;
        r_prev  <= r_sync2;
      end
    end

    assign fall[i] = (r_prev == c_idle) && (r_sync2 == BTN_ACTIVE);
  end

endmodule
`default_nettype wire

// File: rtl/move_tick_gen.sv
`default_nettype none
// ============================================================================
// Module : move_tick_gen
// Brief  : Floor-to-floor movement timebase. Emits a one-cycle move_tick and
//          toggles move_clk every period (normal or fast), freezes while an
//          emergency stop or overload is active, and restarts the period on
//          a call-button press while the cabin is stationary.
// Rev    : 1.0  initial release
// ============================================================================
module move_tick_gen
  import elevator_pkg::*;
#(
  parameter int NUM_BTN   = 3,
  parameter int CNT_W     = 26,
  parameter int MOVE_TIME = MOVE_TIME_DEF,
  parameter int FAST_TIME = FAST_TIME_DEF,
  parameter int TICK_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] call_btn,
  input  logic               moving,
  input  logic               sos_mode,
  input  logic               weight_limit_exceeded,
  input  logic               fast_mode,
  output logic               move_tick,
  output logic               move_clk,
  output logic               halted,
  output logic [TICK_W-1:0]  tick_count,
  output logic [CNT_W-1:0]   cnt_dbg
);

  localparam logic [CNT_W-1:0]  c_move_p = CNT_W'(MOVE_TIME);
  localparam logic [CNT_W-1:0]  c_fast_p = CNT_W'(FAST_TIME);
  localparam logic [CNT_W-1:0]  c_cnt_one = CNT_W'(1);
  localparam logic [TICK_W-1:0] c_tick_one = TICK_W'(1);
  localparam logic [TICK_W-1:0] c_tick_max = {TICK_W{1'b1}};

  logic [NUM_BTN-1:0] w_fall;
  logic               w_press;
  logic               w_restart;
  logic               w_halt_req;
  logic               w_run_en;
  logic               w_terminal;
  logic [CNT_W-1:0]   w_period;

  state_e             r_state;
  state_e             w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_period;
  logic               r_tick;
  logic               r_mclk;
  logic [TICK_W-1:0]  r_tick_cnt;

  btn_sync_edge #(
    .NUM_BTN (NUM_BTN)
  ) u_btn (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (call_btn),
    .fall    (w_fall)
  );

  assign w_press    = |w_fall;
  assign w_restart  = w_press & ~moving;
  assign w_halt_req = sos_mode | weight_limit_exceeded;

  // Period selection is only re-evaluated at the start of a period
  assign w_period   = (r_cnt == '0) ? (fast_mode ? c_fast_p : c_move_p) : r_period;
  assign w_terminal = (r_cnt == (w_period - c_cnt_one));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_RUN;
    else        r_state <= w_state_next;
  end

  // Next-state logic: hold while any halt request is present
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN:  if (w_halt_req)  w_state_next = ST_HOLD;
      ST_HOLD: if (!w_halt_req) w_state_next = ST_RUN;
      default: w_state_next = ST_RUN;
    endcase
  end

  // State outputs: counting is allowed only when heading into RUN, so a halt
  // request freezes the counter in the same cycle it appears
  always_comb begin
    halted   = (r_state == ST_HOLD);
    w_run_en = (w_state_next == ST_RUN);
  end

  // Period counter, tick pulse, toggle clock and saturating tick counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_period   <= c_move_p;
      r_tick     <= 1'b0;
      r_mclk     <= 1'b0;
      r_tick_cnt <= '0;
    end else begin
      r_tick   <= 1'b0;
      r_period <= w_period;
      if (w_restart) begin
        r_cnt      <= '0;
        r_mclk     <= 1'b0;
        r_tick_cnt <= '0;
      end else if (w_run_en) begin
        if (w_terminal) begin
          r_cnt  <= '0;
          r_tick <= 1'b1;
          r_mclk <= ~r_mclk;
          if (r_tick_cnt != c_tick_max) r_tick_cnt <= r_tick_cnt + c_tick_one;
        end else begin
          r_cnt <= r_cnt + c_cnt_one;
        end
      end
    end
  end

  assign move_tick  = r_tick;
  assign move_clk   = r_mclk;
  assign tick_count = r_tick_cnt;
  assign cnt_dbg    = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_move_tick_gen.sv
`default_nettype none
// ============================================================================
// Module : tb_move_tick_gen
// Brief  : Self-checking bench for move_tick_gen: a directed vector table
//          for the free-running, fast, hold and restart timeline, plus short
//          hand-written sequences for restart corners, async reset and
//          tick counter saturation.
// Rev    : 1.0  initial release
// ============================================================================
module tb_move_tick_gen;

  typedef struct {
    logic [2:0]  btn;
    logic        mov;
    logic        sos;
    logic        wle;
    logic        fast;
    int          n;
    logic        tick;
    logic        mclk;
    logic        hlt;
    logic [7:0]  tc;
    logic [25:0] cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  call_btn;
  logic        moving;
  logic        sos_mode;
  logic        weight_limit_exceeded;
  logic        fast_mode;
  logic        move_tick;
  logic        move_clk;
  logic        halted;
  logic [7:0]  tick_count;
  logic [25:0] cnt_dbg;

  logic        rst2_n;
  logic        move_tick2;
  logic        move_clk2;
  logic        halted2;
  logic [1:0]  tick_count2;
  logic [25:0] cnt_dbg2;

  int errors = 0;
  int checks = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  move_tick_gen dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .call_btn              (call_btn),
    .moving                (moving),
    .sos_mode              (sos_mode),
    .weight_limit_exceeded (weight_limit_exceeded),
    .fast_mode             (fast_mode),
    .move_tick             (move_tick),
    .move_clk              (move_clk),
    .halted                (halted),
    .tick_count            (tick_count),
    .cnt_dbg               (cnt_dbg)
  );

  move_tick_gen #(.TICK_W(2)) dut2 (
    .clk                   (clk),
    .rst_n                 (rst2_n),
    .call_btn              (3'b111),
    .moving                (1'b0),
    .sos_mode              (1'b0),
    .weight_limit_exceeded (1'b0),
    .fast_mode             (1'b0),
    .move_tick             (move_tick2),
    .move_clk              (move_clk2),
    .halted                (halted2),
    .tick_count            (tick_count2),
    .cnt_dbg               (cnt_dbg2)
  );

  function automatic vec_t mk(input logic [2:0] btn, input logic mov, input logic sos,
                              input logic wle, input logic fast, input int n,
                              input logic tick, input logic mclk, input logic hlt,
                              input logic [7:0] tc, input logic [25:0] cnt);
    vec_t v;
    v.btn = btn; v.mov = mov; v.sos = sos; v.wle = wle; v.fast = fast; v.n = n;
    v.tick = tick; v.mclk = mclk; v.hlt = hlt; v.tc = tc; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] at %0t: got %0d, expected %0d", nm, idx, $time, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // btn, mov, sos, wle, fast, n | tick, mclk, halted, tick_count, cnt
    vecs.push_back(mk(3'b111,0,0,0,0, 9, 0,0,0, 0,9));
    vecs.push_back(mk(3'b111,0,0,0,0, 1, 1,1,0, 1,0));
    vecs.push_back(mk(3'b111,0,0,0,0, 1, 0,1,0, 1,1));
    vecs.push_back(mk(3'b111,0,0,0,0, 9, 1,0,0, 2,0));
    vecs.push_back(mk(3'b111,0,0,0,0,10, 1,1,0, 3,0));
    vecs.push_back(mk(3'b111,0,0,0,0, 4, 0,1,0, 3,4));
    vecs.push_back(mk(3'b111,0,0,0,1, 1, 0,1,0, 3,5));
    vecs.push_back(mk(3'b111,0,0,0,1, 5, 1,0,0, 4,0));
    vecs.push_back(mk(3'b111,0,0,0,1, 5, 1,1,0, 5,0));
    vecs.push_back(mk(3'b111,0,0,0,1, 4, 0,1,0, 5,4));
    vecs.push_back(mk(3'b111,0,0,0,1, 1, 1,0,0, 6,0));
    vecs.push_back(mk(3'b111,0,0,0,0, 5, 0,0,0, 6,5));
    vecs.push_back(mk(3'b111,0,0,0,0, 5, 1,1,0, 7,0));
    vecs.push_back(mk(3'b111,0,0,0,0, 6, 0,1,0, 7,6));
    vecs.push_back(mk(3'b111,0,1,0,0, 1, 0,1,1, 7,6));
    vecs.push_back(mk(3'b111,0,1,0,0, 6, 0,1,1, 7,6));
    vecs.push_back(mk(3'b111,0,0,0,0, 1, 0,1,0, 7,7));
    vecs.push_back(mk(3'b111,0,0,0,0, 2, 0,1,0, 7,9));
    vecs.push_back(mk(3'b111,0,0,0,0, 1, 1,0,0, 8,0));
    vecs.push_back(mk(3'b111,0,0,0,0, 9, 0,0,0, 8,9));
    vecs.push_back(mk(3'b111,0,0,1,0, 1, 0,0,1, 8,9));
    vecs.push_back(mk(3'b111,0,0,1,0, 2, 0,0,1, 8,9));
    vecs.push_back(mk(3'b111,0,0,0,0, 1, 1,1,0, 9,0));
    vecs.push_back(mk(3'b111,0,0,0,0, 8, 0,1,0, 9,8));
    vecs.push_back(mk(3'b101,0,0,0,0, 2, 1,0,0,10,0));
    vecs.push_back(mk(3'b101,0,0,0,0, 1, 0,0,0, 0,0));
    vecs.push_back(mk(3'b101,0,0,0,0, 9, 0,0,0, 0,9));
    vecs.push_back(mk(3'b101,0,0,0,0, 1, 1,1,0, 1,0));
    vecs.push_back(mk(3'b111,0,0,0,0, 1, 0,1,0, 1,1));
    vecs.push_back(mk(3'b111,0,0,0,0, 7, 0,1,0, 1,8));
    vecs.push_back(mk(3'b101,1,0,0,0, 2, 1,0,0, 2,0));
    vecs.push_back(mk(3'b101,1,0,0,0, 1, 0,0,0, 2,1));
    vecs.push_back(mk(3'b111,0,0,0,0, 1, 0,0,0, 2,2));

    rst_n = 1'b0; rst2_n = 1'b0;
    call_btn = 3'b111; moving = 1'b0; sos_mode = 1'b0;
    weight_limit_exceeded = 1'b0; fast_mode = 1'b0;
    step(2);
    chk("rst_tick",  0, 32'(move_tick),  0);
    chk("rst_mclk",  0, 32'(move_clk),   0);
    chk("rst_halt",  0, 32'(halted),     0);
    chk("rst_tc",    0, 32'(tick_count), 0);
    chk("rst_cnt",   0, 32'(cnt_dbg),    0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      call_btn = vecs[i].btn; moving = vecs[i].mov; sos_mode = vecs[i].sos;
      weight_limit_exceeded = vecs[i].wle; fast_mode = vecs[i].fast;
      step(vecs[i].n);
      chk("tick", i, 32'(move_tick),  32'(vecs[i].tick));
      chk("mclk", i, 32'(move_clk),   32'(vecs[i].mclk));
      chk("halt", i, 32'(halted),     32'(vecs[i].hlt));
      chk("tc",   i, 32'(tick_count), 32'(vecs[i].tc));
      chk("cnt",  i, 32'(cnt_dbg),    32'(vecs[i].cnt));
    end

    // Restart lands on the terminal-count cycle: restart wins, no tick
    step(15);
    chk("pre_rw_cnt",  0, 32'(cnt_dbg),  7);
    chk("pre_rw_mclk", 0, 32'(move_clk), 1);
    call_btn = 3'b110;
    step(2);
    chk("rw_term_cnt", 0, 32'(cnt_dbg), 9);
    step(1);
    chk("rw_tick", 0, 32'(move_tick),  0);
    chk("rw_tc",   0, 32'(tick_count), 0);
    chk("rw_cnt",  0, 32'(cnt_dbg),    0);
    call_btn = 3'b111;
    step(10);
    chk("rw_next_tick", 0, 32'(move_tick), 1);
    chk("rw_next_mclk", 0, 32'(move_clk),  1);

    // Restart while in HOLD clears move_clk and tick_count, state stays HOLD
    call_btn = 3'b011; sos_mode = 1'b1;
    step(3);
    chk("rh_mclk", 0, 32'(move_clk),   0);
    chk("rh_tc",   0, 32'(tick_count), 0);
    chk("rh_halt", 0, 32'(halted),     1);
    chk("rh_cnt",  0, 32'(cnt_dbg),    0);
    call_btn = 3'b111; sos_mode = 1'b0;
    step(10);
    chk("rh_next_tick", 0, 32'(move_tick), 1);
    chk("rh_next_mclk", 0, 32'(move_clk),  1);
    step(5);
    chk("ar_pre_cnt", 0, 32'(cnt_dbg), 5);

    // Asynchronous reset mid-period, no clock edge in between
    #2 rst_n = 1'b0;
    #1;
    chk("ar_tick", 0, 32'(move_tick),  0);
    chk("ar_mclk", 0, 32'(move_clk),   0);
    chk("ar_tc",   0, 32'(tick_count), 0);
    chk("ar_cnt",  0, 32'(cnt_dbg),    0);
    #1 rst_n = 1'b1;
    step(9);
    chk("ar_cnt9", 0, 32'(cnt_dbg),   9);
    chk("ar_t9",   0, 32'(move_tick), 0);
    step(1);
    chk("ar_tick10", 0, 32'(move_tick),  1);
    chk("ar_tc10",   0, 32'(tick_count), 1);

    // Two-bit tick counter saturates at 3
    rst2_n = 1'b1;
    step(30);
    chk("sat_tc3", 0, 32'(tick_count2), 3);
    step(10);
    chk("sat_tc4", 0, 32'(tick_count2), 3);
    step(10);
    chk("sat_tick5", 0, 32'(move_tick2),  1);
    chk("sat_tc5",   0, 32'(tick_count2), 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
